csa_accum_sequencer: RTL and testbench

//   Sequential multi-operand adder built on one 16-bit 3:2 carry-save stage plus one 16-bit CLA.

---
 rtl/csa_accum_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_csa_accum_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/csa_accum_sequencer.sv
// Sequential multi-operand adder: one 3:2 carry-save stage accumulates a frame of
// operands in redundant form, and one carry-lookahead adder resolves the total at frame close.

module csa_accum_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_c;
    assign o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

// Carry-lookahead adder built from 4-bit lookahead groups; group carries chain between groups.
module csa_accum_cla #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [NG:0]      w_gc;

    assign w_g     = i_a & i_b;
    assign w_p     = i_a ^ i_b;
    assign w_gc[0] = i_cin;
    assign o_cout  = w_gc[NG];

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        logic [3:0] w_gg;
        logic [3:0] w_pp;
        logic [3:0] w_cc;
        logic       w_grp_g;
        logic       w_grp_p;

        assign w_gg = w_g[gi*4 +: 4];
        assign w_pp = w_p[gi*4 +: 4];

        assign w_cc[0] = w_gc[gi];
        assign w_cc[1] = w_gg[0] | (w_pp[0] & w_gc[gi]);
        assign w_cc[2] = w_gg[1] | (w_pp[1] & w_gg[0]) | (w_pp[1] & w_pp[0] & w_gc[gi]);
        assign w_cc[3] = w_gg[2] | (w_pp[2] & w_gg[1]) | (w_pp[2] & w_pp[1] & w_gg[0])
                       | (w_pp[2] & w_pp[1] & w_pp[0] & w_gc[gi]);

        assign w_grp_p = &w_pp;
        assign w_grp_g = w_gg[3] | (w_pp[3] & w_gg[2]) | (w_pp[3] & w_pp[2] & w_gg[1])
                       | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0]);

        assign w_gc[gi+1]       = w_grp_g | (w_grp_p & w_gc[gi]);
        assign o_sum[gi*4 +: 4] = w_pp ^ w_cc;
    end
endmodule

module csa_accum_sequencer #(
    parameter int WIDTH   = 16,
    parameter int MAX_OPS = 9,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);
    localparam logic             ONE_OP  = (MAX_OPS == 1);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_c;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_ovf;
    logic [CNT_W-1:0] r_out_count;

    logic [WIDTH-1:0] w_c_sh;
    logic             w_c_drop;
    logic [WIDTH-1:0] w_csa_s;
    logic [WIDTH-1:0] w_csa_c;
    logic [WIDTH-1:0] w_cla_sum;
    logic             w_cla_cout;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_ld_first;
    logic             w_step;
    logic             w_resolve;

    // Carry word is stored at its own bit positions; its weight is doubled on use,
    // so the MSB falls off as exactly 2^WIDTH of lost total.
    assign w_c_sh    = {r_c[WIDTH-2:0], 1'b0};
    assign w_c_drop  = r_c[WIDTH-1];
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_in_fire = in_valid & in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    csa_accum_fa u_fa [WIDTH-1:0] (
        .i_a  (r_s),
        .i_b  (w_c_sh),
        .i_c  (in_data),
        .o_s  (w_csa_s),
        .o_co (w_csa_c)
    );

    csa_accum_cla #(.WIDTH(WIDTH)) u_cla (
        .i_a    (r_s),
        .i_b    (w_c_sh),
        .i_cin  (1'b0),
        .o_sum  (w_cla_sum),
        .o_cout (w_cla_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_in_fire)
                        w_state_nxt = (in_last || ONE_OP) ? ST_RESOLVE : ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (w_in_fire && (in_last || (w_cnt_inc == MAX_CNT)))
                        w_state_nxt = ST_RESOLVE;
                end
                ST_RESOLVE: w_state_nxt = ST_DONE;
                ST_DONE: begin
                    if (w_out_fire) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready   = ((r_state == ST_IDLE) || (r_state == ST_ACCUM)) && !abort;
        w_ld_first = 1'b0;
        w_step     = 1'b0;
        w_resolve  = 1'b0;
        case (r_state)
            ST_IDLE:    w_ld_first = w_in_fire;
            ST_ACCUM:   w_step     = w_in_fire;
            ST_RESOLVE: w_resolve  = !abort;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_s   <= '0;
            r_c   <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_ld_first) begin
            r_s   <= in_data;
            r_c   <= '0;
            r_cnt <= CNT_W'(1);
            r_ovf <= 1'b0;
        end else if (w_step) begin
            r_s   <= w_csa_s;
            r_c   <= w_csa_c;
            r_cnt <= w_cnt_inc;
            r_ovf <= r_ovf | w_c_drop;
        end
    end

    // Result registers survive abort and the output beat; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_count <= '0;
        end else if (abort) begin
            r_out_valid <= 1'b0;
        end else if (w_resolve) begin
            r_out_sum   <= w_cla_sum;
            r_out_ovf   <= r_ovf | w_c_drop | w_cla_cout;
            r_out_count <= r_cnt;
            r_out_valid <= 1'b1;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_ovf   = r_out_ovf;
    assign out_count = r_out_count;

endmodule

// File: tb/tb_csa_accum_sequencer.sv
// Randomized frame-level check of csa_accum_sequencer against an integer-sum reference.
module tb_csa_accum_sequencer;
    localparam int W    = 16;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst, abort, in_valid, in_last, out_ready;
    logic [W-1:0]  in_data;
    logic          in_ready, out_valid, out_ovf;
    logic [W-1:0]  out_sum;
    logic [CW-1:0] out_count;

    int            n_chk  = 0;
    int            n_fail = 0;
    logic [W-1:0]  ops[$];

    always #5 clk = ~clk;

    csa_accum_sequencer #(.WIDTH(W), .MAX_OPS(9), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .out_count(out_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_op(input logic [W-1:0] d, input logic last);
        int b;
        b = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        forever begin
            #1;
            if (in_ready) begin
                tick();
                break;
            end
            tick();
            b++;
            if (b > 30) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Frame closes on the final op (in_last when use_last, or the 9th op).
    task automatic run_frame(input bit use_last, input int stall, input int gap_max);
        longint tot;
        int     n;
        logic [W-1:0] exp_sum;
        logic   exp_ovf;
        tot = 0;
        n   = ops.size();
        for (int i = 0; i < n; i++) begin
            tot += longint'(ops[i]);
            if (gap_max > 0) begin
                int g;
                g = $urandom_range(gap_max, 0);
                repeat (g) begin
                    in_valid = 1'b0;
                    #1;
                    chk("gap_ready", in_ready, 1);
                    tick();
                end
            end
            send_op(ops[i], use_last && (i == n - 1));
        end
        exp_sum = tot[W-1:0];
        exp_ovf = (tot >= 65536);
        // A pending beat must not be taken while the result is being produced.
        in_valid  = 1'b1;
        in_data   = 16'hBEEF;
        out_ready = 1'b0;
        #1;
        chk("resolve_valid", out_valid, 0);
        chk("resolve_ready", in_ready, 0);
        tick();
        repeat (stall) begin
            #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_ready", in_ready, 0);
            chk("stall_sum", out_sum, exp_sum);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("done_valid", out_valid, 1);
        chk("done_ready", in_ready, 0);
        chk("sum", out_sum, exp_sum);
        chk("ovf", out_ovf, exp_ovf);
        chk("count", out_count, n);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("post_valid", out_valid, 0);
        chk("post_ready", in_ready, 1);
        chk("held_sum", out_sum, exp_sum);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_ovf", out_ovf, 0);
        chk("rst_count", out_count, 0);
        chk("rst_ready", in_ready, 1);
        tick();

        ops = {};
        for (int i = 1; i <= 9; i++) ops.push_back(W'(i));
        run_frame(1, 0, 0);

        ops = {16'hABCD};
        run_frame(1, 2, 0);

        ops = {16'hFFFF, 16'h0001};
        run_frame(1, 0, 0);
        ops = {16'h7FFF, 16'h8000};
        run_frame(1, 1, 0);

        ops = {};
        repeat (9) ops.push_back(16'h2000);
        run_frame(0, 3, 0);

        ops = {16'h1234, 16'h4321, 16'h0F0F};
        run_frame(1, 5, 1);

        // abort after three operands; the operand in the abort cycle is dropped
        send_op(16'h1111, 1'b0);
        send_op(16'h2222, 1'b0);
        send_op(16'h3333, 1'b0);
        abort = 1'b1; in_valid = 1'b1; in_data = 16'h7777;
        #1;
        chk("abort_ready", in_ready, 0);
        tick();
        abort = 1'b0; in_valid = 1'b0;
        #1;
        chk("post_abort_ready", in_ready, 1);
        chk("post_abort_valid", out_valid, 0);
        tick();
        ops = {16'h0005, 16'h0007};
        run_frame(1, 0, 0);

        // reset while an unread result sits in DONE
        send_op(16'h4444, 1'b0);
        send_op(16'h0101, 1'b1);
        tick();
        #1;
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) begin
            #1;
            chk("rst_done_valid", out_valid, 0);
            chk("rst_done_ready", in_ready, 1);
            tick();
        end
        chk("rst_done_sum", out_sum, 0);
        chk("rst_done_count", out_count, 0);
        ops = {16'h0005, 16'h0007};
        run_frame(1, 0, 0);

        for (int f = 0; f < 40; f++) begin
            int  n;
            bit  ul;
            n  = $urandom_range(9, 1);
            ul = (n < 9) ? 1'b1 : 1'($urandom_range(1, 0));
            ops = {};
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(1, 0) == 1) ops.push_back(W'($urandom_range(4000, 0)));
                else                           ops.push_back(W'($urandom));
            end
            run_frame(ul, $urandom_range(3, 0), 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
